sum_sq: RTL and testbench

SUM_SQ -- requirements
Module: sum_sq

---
 rtl/sum_sq_pkg.sv | 14 +
 rtl/sum_sq_if.sv | 33 +++
 rtl/sum_sq_abs.sv | 30 +++
 rtl/sum_sq.sv | 121 ++++++++++++
 tb/tb_sum_sq.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/sum_sq_pkg.sv
// Shared constants and state encoding for the sum-of-squares block.
package sum_sq_pkg;

    localparam int unsigned IN_W_DEF   = 8;
    localparam int unsigned SUM_SQ_LAT = 2 * IN_W_DEF + 1;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StSqx  = 2'd1;
    localparam state_t StSqy  = 2'd2;
    localparam state_t StDone = 2'd3;

endpackage

// File: rtl/sum_sq_if.sv
// Operand handshake and result bus between the pair source, sum_sq and the square-root unit.
interface sum_sq_if
    import sum_sq_pkg::*;
#(
    parameter int unsigned IN_W = IN_W_DEF
);

    logic                   in_valid;
    logic                   in_ready;
    logic signed [IN_W-1:0] x;
    logic signed [IN_W-1:0] y;
    logic                   sqrt_en;
    logic [2*IN_W-1:0]      din;

    modport master (
        output in_valid,
        output x,
        output y,
        input  in_ready,
        input  sqrt_en,
        input  din
    );

    modport slave (
        input  in_valid,
        input  x,
        input  y,
        output in_ready,
        output sqrt_en,
        output din
    );

endinterface

// File: rtl/sum_sq_abs.sv
// Unsigned magnitude of a signed operand; with SUM_SQ_CLIP_EN the most-negative value is
// first clipped to -(2^(IN_W-1)-1).
module sum_sq_abs
    import sum_sq_pkg::*;
#(
    parameter int unsigned IN_W = IN_W_DEF
) (
    input  logic signed [IN_W-1:0] val,
    output logic [IN_W-1:0]        mag
);

`ifdef SUM_SQ_CLIP_EN
    localparam logic [IN_W-1:0] MinNeg = {1'b1, {(IN_W-1){1'b0}}};
    localparam logic [IN_W-1:0] One    = {{(IN_W-1){1'b0}}, 1'b1};
`endif

    logic [IN_W-1:0] src;

    always_comb begin
        src = $unsigned(val);
`ifdef SUM_SQ_CLIP_EN
        if (src == MinNeg) begin
            src = MinNeg + One;
        end
`endif
        // Unsigned result keeps 2^(IN_W-1) representable for the unclipped minimum.
        mag = src[IN_W-1] ? (~src + 1'b1) : src;
    end

endmodule

// File: rtl/sum_sq.sv
// Serial shift-and-add computation of x*x + y*y for the downstream square-root unit.
// Optional build macro: SUM_SQ_CLIP_EN (clip the most-negative input before squaring).
module sum_sq
    import sum_sq_pkg::*;
#(
    parameter int unsigned IN_W = IN_W_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    sum_sq_if.slave  bus
);

    localparam int unsigned AccW = 2 * IN_W;
    localparam int unsigned CntW = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(IN_W - 1);

    state_t          state_q, state_d;
    logic [IN_W-1:0] mag_x, mag_y;
    logic [IN_W-1:0] ax_q, ay_q;
    logic [IN_W-1:0] op;
    logic [AccW-1:0] addend;
    logic [AccW-1:0] acc_q, acc_d;
    logic [AccW-1:0] din_q, din_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sqrt_en_q, sqrt_en_d;
    logic            accept;

    sum_sq_abs #(
        .IN_W (IN_W)
    ) u_abs_x (
        .val (bus.x),
        .mag (mag_x)
    );

    sum_sq_abs #(
        .IN_W (IN_W)
    ) u_abs_y (
        .val (bus.y),
        .mag (mag_y)
    );

    assign bus.in_ready = (state_q == StIdle);
    assign bus.sqrt_en  = sqrt_en_q;
    assign bus.din      = din_q;
    assign accept       = (state_q == StIdle) && bus.in_valid;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        din_d     = din_q;
        sqrt_en_d = 1'b0;

        // One operand is squared per phase: bit k of the magnitude gates (mag << k).
        op     = (state_q == StSqy) ? ay_q : ax_q;
        addend = op[cnt_q] ? (AccW'(op) << cnt_q) : '0;

        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    state_d = StSqx;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            StSqx: begin
                acc_d = acc_q + addend;
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = StSqy;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StSqy: begin
                acc_d = acc_q + addend;
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                sqrt_en_d = 1'b1;
                din_d     = acc_q;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            cnt_q     <= '0;
            din_q     <= '0;
            sqrt_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            din_q     <= din_d;
            sqrt_en_q <= sqrt_en_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ax_q <= '0;
            ay_q <= '0;
        end else if (accept) begin
            ax_q <= mag_x;
            ay_q <= mag_y;
        end
    end

endmodule

// File: tb/tb_sum_sq.sv
// Scoreboard bench for sum_sq: an acceptance tracker queues expected results from a plain
// arithmetic model, and an output monitor pops and compares on each sqrt_en pulse.
module tb_sum_sq;

    localparam int unsigned IN_W   = 8;
    localparam int          LAT    = 17;
    localparam int          PERIOD = 18;

    typedef struct {
        int unsigned din;
        int          cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sum_sq_if #(.IN_W(IN_W)) bus ();

    sum_sq #(
        .IN_W (IN_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t        sb[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          cyc        = 0;
    int          last_acc   = 0;
    bit          have_acc   = 1'b0;
    bit          burst      = 1'b0;
    bit          prev_valid = 1'b0;
    int          prev_pulse = 0;
    int unsigned held       = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int unsigned ref_sq(logic signed [7:0] a, logic signed [7:0] b);
        int ia;
        int ib;
        ia = a;
        ib = b;
`ifdef SUM_SQ_CLIP_EN
        if (ia == -128) ia = -127;
        if (ib == -128) ib = -127;
`endif
        return int'(ia * ia + ib * ib);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Acceptance tracker: in_ready follows from the model's own busy window.
    always @(negedge clk) begin
        logic exp_rdy;
        if (!rst_n) begin
            have_acc = 1'b0;
        end else begin
            exp_rdy = !have_acc || (cyc >= last_acc + LAT);
            check("in_ready", 32'(bus.in_ready), exp_rdy ? 32'd1 : 32'd0);
            if (bus.in_valid && exp_rdy) begin
                sb.push_back('{ref_sq(bus.x, bus.y), cyc + 1 + LAT});
                last_acc = cyc + 1;
                have_acc = 1'b1;
            end
        end
    end

    // Output monitor.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            check("reset_sqrt_en", 32'(bus.sqrt_en), 32'd0);
            check("reset_din", 32'(bus.din), 32'd0);
            sb.delete();
            held       = 0;
            prev_valid = 1'b0;
        end else begin
            if (sb.size() > 0 && cyc > sb[0].cyc) begin
                fail_now("missing_pulse");
                void'(sb.pop_front());
            end
            if (bus.sqrt_en) begin
                if (sb.size() == 0) begin
                    fail_now("spurious_pulse");
                end else begin
                    e = sb.pop_front();
                    check("din", 32'(bus.din), e.din);
                    check("latency", cyc, e.cyc);
                    held = e.din;
                    if (burst && prev_valid) check("pulse_gap", cyc - prev_pulse, PERIOD);
                    prev_pulse = cyc;
                    prev_valid = burst;
                end
            end else begin
                check("din_hold", 32'(bus.din), held);
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic signed [7:0] xv, input logic signed [7:0] yv);
        bit ok;
        ok           = 1'b0;
        bus.in_valid = 1'b1;
        bus.x        = xv;
        bus.y        = yv;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("send_timeout");
        sync();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_pulse(input int unsigned req, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.sqrt_en) begin
                check(name, 32'(bus.din), req);
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_now({name, "_timeout"});
        sync();
    endtask

    task automatic drain();
        bit empty;
        empty = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                empty = 1'b1;
                break;
            end
        end
        if (!empty) fail_now("drain_timeout");
        sync();
    endtask

    initial begin
        logic signed [7:0] corners [4];
        corners = '{8'sh80, 8'sh7f, 8'sh00, 8'shff};

        bus.in_valid = 1'b0;
        bus.x        = '0;
        bus.y        = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        send(8'sd3, 8'sd4);
        wait_pulse(25, "dir_3_4");
        send(8'sh80, 8'sh80);
`ifdef SUM_SQ_CLIP_EN
        wait_pulse(32258, "dir_min_min");
`else
        wait_pulse(32768, "dir_min_min");
`endif
        send(8'sd0, 8'sd0);
        wait_pulse(0, "dir_0_0");
        send(-8'sd1, 8'sd127);
        wait_pulse(16130, "dir_m1_127");

        // Continuous valid with fresh operands every cycle.
        burst = 1'b1;
        for (int i = 0; i < 40 * PERIOD; i++) begin
            bus.in_valid = 1'b1;
            bus.x        = IN_W'($urandom_range(0, 255));
            bus.y        = IN_W'($urandom_range(0, 255));
            sync();
        end
        bus.in_valid = 1'b0;
        drain();
        burst = 1'b0;

        // Reset five cycles into the second squaring phase.
        send(8'sd100, 8'sd50);
        repeat (13) @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(bus.in_ready), 32'd1);
        check("din_after_reset", 32'(bus.din), 32'd0);
        sync();
        send(8'sd5, 8'sd12);
        wait_pulse(169, "dir_5_12");

        // Random sweep with in_valid toggling, including while busy.
        for (int i = 0; i < 30000; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) bus.x = corners[$urandom_range(0, 3)];
            else bus.x = IN_W'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) bus.y = corners[$urandom_range(0, 3)];
            else bus.y = IN_W'($urandom_range(0, 255));
            sync();
        end
        bus.in_valid = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout (t=%0t)", $time);
        $fatal(1, "simulation time limit reached");
    end

endmodule
